jtpang_busarb: RTL

JTPANG_BUSARB -- requirements
Module: jtpang_busarb

---
 rtl/jtpang_pkg.sv | 25 ++
 rtl/jtpang_satcnt.sv | 45 ++++
 rtl/jtpang_busarb.sv | 126 ++++++++++++
 3 files changed

// File: rtl/jtpang_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtpang_pkg
//  Description : Shared types and constants for the object-DMA bus arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package jtpang_pkg;

    // Arbiter states: idle, request pending on a busy bus, bus granted,
    // and post-release cool-down.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GRANT = 2'd2,
        ST_GAP   = 2'd3
    } busarb_state_e;

    // Default number of cpu_cen ticks between a release and the next grant.
    localparam int unsigned REL_GAP_DEF = 2;

    // Width of the granted-tick statistics counter.
    localparam int unsigned GRANT_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/jtpang_satcnt.sv
`default_nettype none
// ============================================================================
//  Module      : jtpang_satcnt
//  Description : Up-counter that sticks at its all-ones value instead of
//                wrapping.
//  Revision    : 1.0  initial release
// ============================================================================
module jtpang_satcnt #(
    parameter int unsigned WIDTH = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             w_full;

    assign w_full = &cnt_q;

    // Next value: advance when enabled unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && !w_full) begin
            cnt_d = cnt_q + C_ONE;
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/jtpang_busarb.sv
`default_nettype none
// ============================================================================
//  Module      : jtpang_busarb
//  Description : Arbitrates the VRAM bus between the CPU and the object DMA
//                engine. The DMA is granted only on an idle CPU bus cycle,
//                the CPU is stalled through its clock enable while granted,
//                and a short cool-down separates a release from the next
//                grant.
//  Revision    : 1.0  initial release
// ============================================================================
module jtpang_busarb
    import jtpang_pkg::*;
#(
    parameter logic [11:0] DMA_BASE = 12'hE00,
    parameter int unsigned REL_GAP  = REL_GAP_DEF
)(
    input  logic        rst,
    input  logic        clk,
    input  logic        cpu_cen,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        cpu_wr_n,
    input  logic [11:0] cpu_addr,
    input  logic        busrq,
    input  logic [8:0]  dma_addr,
    output logic        busak_n,
    output logic        cpu_cen_g,
    output logic [11:0] vram_addr,
    output logic        vram_wr_n,
    output logic [15:0] grant_cnt
);

    // Gap counter only needs to reach REL_GAP-1.
    localparam int unsigned     GAP_W    = (REL_GAP > 1) ? $clog2(REL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(REL_GAP - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    busarb_state_e    state_q;
    busarb_state_e    state_d;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_d;
    logic             busak_n_q;

    logic             w_bus_idle;
    logic             w_granted;

    // The CPU bus is free when neither a memory nor an I/O cycle is running.
    assign w_bus_idle = mreq_n & iorq_n;
    assign w_granted  = (state_q == ST_GRANT);

    // Next-state logic. Decisions are taken on cpu_cen ticks only, except
    // that a pending request withdrawn in WAIT is dropped immediately; that
    // same check also wins over a grant on the tick busrq falls.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_cen && busrq) begin
                    state_d = w_bus_idle ? ST_GRANT : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!busrq) begin
                    state_d = ST_IDLE;
                end else if (cpu_cen && w_bus_idle) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (cpu_cen && !busrq) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                if (cpu_cen) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = ST_IDLE;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + GAP_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gap_d   = '0;
            end
        endcase
    end

    // State, gap counter and acknowledge registers. The acknowledge trails
    // the state by one clk so it reflects a grant already in force.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gap_q     <= '0;
            busak_n_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            busak_n_q <= !w_granted;
        end
    end

    assign busak_n   = busak_n_q;

    // CPU is frozen while the DMA owns the bus.
    assign cpu_cen_g = cpu_cen & ~w_granted;

    // VRAM port follows the owner straight from the state register.
    assign vram_addr = w_granted ? (DMA_BASE | {3'b000, dma_addr}) : cpu_addr;
    assign vram_wr_n = w_granted ? 1'b1 : cpu_wr_n;

    jtpang_satcnt #(
        .WIDTH (GRANT_CNT_W)
    ) u_grant_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (cpu_cen & w_granted),
        .cnt_o (grant_cnt)
    );

endmodule
`default_nettype wire
